// File: rtl/mem_bridge_pkg.sv
// Shared types for mem_bridge: FSM state encoding and the default completion timeout.
package mem_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      DONE  = 3'd3,
      ERR   = 3'd4
   } state_t;

   localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/mem_bridge_wait_timer.sv
// Saturating wait counter; tc_o flags TIMEOUT-1, the last WAIT cycle before a timeout.
// Clear wins over enable; the count never wraps.
module wait_timer
   import mem_bridge_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic clock,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != TC_VAL)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/mem_bridge.sv
// CPU-to-memory bridge: one access per request, cpu_ready one cycle after the accepted mem_valid, timeout to cpu_err.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned addresses straight to error; all outputs are registered.
module mem_bridge
   import mem_bridge_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ready,
   output logic              cpu_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_valid
);

   state_t            state_q;
   logic              we_q, mem_en_q, cpu_ready_q, cpu_err_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, rdata_q;
   logic              misalign, tmr_clr, tmr_en, tmr_tc;

`ifdef MEM_ALIGN_CHECK_EN
   assign misalign = (cpu_addr[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   assign tmr_clr = (state_q == ISSUE);
   assign tmr_en  = (state_q == WAIT) && !mem_valid;

   wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
      .clock (clock),
      .reset (reset),
      .clr_i (tmr_clr),
      .en_i  (tmr_en),
      .tc_o  (tmr_tc)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         mem_en_q    <= 1'b0;
         cpu_ready_q <= 1'b0;
         cpu_err_q   <= 1'b0;
      end else begin
         // Strobes are single-cycle: cleared by default, set only on the entering transition.
         mem_en_q    <= 1'b0;
         cpu_ready_q <= 1'b0;
         cpu_err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (cpu_req) begin
                  we_q    <= cpu_we;
                  addr_q  <= cpu_addr;
                  wdata_q <= cpu_wdata;
                  if (misalign) begin
                     state_q     <= ERR;
                     cpu_ready_q <= 1'b1;
                     cpu_err_q   <= 1'b1;
                  end else begin
                     state_q  <= ISSUE;
                     mem_en_q <= 1'b1;
                  end
               end
            end
            ISSUE: state_q <= WAIT;
            WAIT: begin
               if (mem_valid) begin
                  if (!we_q) begin
                     rdata_q <= mem_rdata;
                  end
                  state_q     <= DONE;
                  cpu_ready_q <= 1'b1;
               end else if (tmr_tc) begin
                  state_q     <= ERR;
                  cpu_ready_q <= 1'b1;
                  cpu_err_q   <= 1'b1;
               end
            end
            DONE:    state_q <= IDLE;
            ERR:     state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cpu_rdata = rdata_q;
   assign cpu_ready = cpu_ready_q;
   assign cpu_err   = cpu_err_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

endmodule
